// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the RV32I instruction encoder: format codes, opcodes,
// FSM state type and an immediate range helper.
package instr_encoder_pkg;

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_J = 3'd4;
    localparam logic [2:0] FMT_U = 3'd5;

    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_JAL    = 7'h6F;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_SYSTEM = 7'h73;

    localparam logic [2:0] F3_SLL = 3'd1;
    localparam logic [2:0] F3_SR  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } enc_state_e;

    // True when v is representable as a bits-wide two's-complement value.
    function automatic logic fits_signed(input logic [31:0] v, input int unsigned bits);
        logic signed [31:0] s;
        s = $signed(v) >>> (bits - 1);
        return (s == 32'sd0) || (s == -32'sd1);
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational RV32I field packer with immediate range/format check.
// An out-of-range or illegal request yields the all-zero (illegal) word.
module instr_pack
    import instr_encoder_pkg::*;
(
    input  logic [2:0]  fmt,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic [31:0] instr,
    output logic        err
);

    logic [31:0] instr_c;
    logic        err_c;
    logic        is_shift;

    assign is_shift = (opcode == OPC_OP_IMM) && ((funct3 == F3_SLL) || (funct3 == F3_SR));

    always_comb begin
        instr_c = '0;
        err_c   = 1'b0;
        case (fmt)
            FMT_R: instr_c = {funct7, rs2, rs1, funct3, rd, opcode};
            FMT_I: begin
                if (is_shift) begin
                    instr_c = {funct7, imm[4:0], rs1, funct3, rd, opcode};
                    err_c   = |imm[31:5];
                end else begin
                    instr_c = {imm[11:0], rs1, funct3, rd, opcode};
                    err_c   = !fits_signed(imm, 12);
                end
            end
            FMT_S: begin
                instr_c = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                err_c   = !fits_signed(imm, 12);
            end
            FMT_B: begin
                instr_c = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                err_c   = !fits_signed(imm, 13) || imm[0];
            end
            FMT_J: begin
                instr_c = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                err_c   = !fits_signed(imm, 21) || imm[0];
            end
            FMT_U: begin
                instr_c = {imm[31:12], rd, opcode};
                err_c   = |imm[11:0];
            end
            default: err_c = 1'b1;
        endcase
    end

    assign instr = err_c ? 32'h0000_0000 : instr_c;
    assign err   = err_c;

endmodule

// File: rtl/instr_encoder.sv
// Burst-bounded RV32I encoder: packs field requests into words and streams them
// to IMEM with an auto-incrementing word address through one output register.
//
// state    | meaning
// ST_IDLE  | waiting for start
// ST_RUN   | accepting requests until remaining reaches zero
// ST_DRAIN | all requests taken, waiting for the last word to leave
// ST_DONE  | one-cycle completion pulse
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [LEN_W-1:0]  len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_fmt,
    input  logic [6:0]        in_opcode,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_err,
    output logic              busy,
    output logic              done,
    output logic [7:0]        err_cnt
);

    enc_state_e        state_q, state_d;
    logic [LEN_W-1:0]  remaining_q, remaining_d;
    logic              out_valid_q, out_valid_d;
    logic [31:0]       out_instr_q, out_instr_d;
    logic              out_err_q, out_err_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic [7:0]        err_cnt_q, err_cnt_d;

    logic [31:0] pack_instr;
    logic        pack_err;
    logic        accept;
    logic        out_hs;

    instr_pack u_pack (
        .fmt    (in_fmt),
        .opcode (in_opcode),
        .funct3 (in_funct3),
        .funct7 (in_funct7),
        .rd     (in_rd),
        .rs1    (in_rs1),
        .rs2    (in_rs2),
        .imm    (in_imm),
        .instr  (pack_instr),
        .err    (pack_err)
    );

    assign in_ready = (state_q == ST_RUN) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign out_hs   = out_valid_q && out_ready;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_err_d   = out_err_q;
        out_addr_d  = out_addr_q;
        err_cnt_d   = err_cnt_q;

        if (out_hs) begin
            out_valid_d = 1'b0;
            out_addr_d  = out_addr_q + 1'b1;
            if (out_err_q && (err_cnt_q != 8'hFF)) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
        end

        // An accept in the same cycle as a drain simply reloads the register.
        if (accept) begin
            out_valid_d = 1'b1;
            out_instr_d = pack_instr;
            out_err_d   = pack_err;
            remaining_d = remaining_q - 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    remaining_d = len;
                    out_addr_d  = start_addr;
                    err_cnt_d   = 8'd0;
                    state_d     = (len == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (accept && (remaining_q == LEN_W'(1))) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!out_valid_q || out_hs) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_err_q   <= 1'b0;
            out_addr_q  <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_err_q   <= out_err_d;
            out_addr_q  <= out_addr_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_instr = out_instr_q;
    assign out_err   = out_err_q;
    assign out_addr  = out_addr_q;
    assign err_cnt   = err_cnt_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: packing vectors, stalls, address wrap,
// error counting, mid-burst reset and zero-length bursts.
module tb_instr_encoder;

    localparam int ADDR_W = 10;
    localparam int LEN_W  = 10;
    localparam int MAXN   = 300;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [ADDR_W-1:0] start_addr;
    logic [LEN_W-1:0]  len;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_fmt;
    logic [6:0]        in_opcode;
    logic [2:0]        in_funct3;
    logic [6:0]        in_funct7;
    logic [4:0]        in_rd, in_rs1, in_rs2;
    logic [31:0]       in_imm;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [ADDR_W-1:0] out_addr;
    logic              out_err;
    logic              busy;
    logic              done;
    logic [7:0]        err_cnt;

    always #5 clk = ~clk;

    instr_encoder #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr), .len(len),
        .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt), .in_opcode(in_opcode),
        .in_funct3(in_funct3), .in_funct7(in_funct7), .in_rd(in_rd), .in_rs1(in_rs1),
        .in_rs2(in_rs2), .in_imm(in_imm), .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_addr(out_addr), .out_err(out_err), .busy(busy),
        .done(done), .err_cnt(err_cnt)
    );

    int total = 0;
    int bad   = 0;

    logic [2:0]  r_fmt [MAXN];
    logic [6:0]  r_op  [MAXN];
    logic [2:0]  r_f3  [MAXN];
    logic [6:0]  r_f7  [MAXN];
    logic [4:0]  r_rd  [MAXN];
    logic [4:0]  r_rs1 [MAXN];
    logic [4:0]  r_rs2 [MAXN];
    logic [31:0] r_imm [MAXN];

    logic [31:0]       got_instr [MAXN];
    logic [ADDR_W-1:0] got_addr  [MAXN];
    logic              got_err   [MAXN];
    int nout, n_stall_viol, done_cnt;

    task automatic set_req(input int i, input logic [2:0] fmt, input logic [6:0] op,
                           input logic [2:0] f3, input logic [6:0] f7, input logic [4:0] rd,
                           input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
        r_fmt[i] = fmt; r_op[i] = op; r_f3[i] = f3; r_f7[i] = f7;
        r_rd[i] = rd; r_rs1[i] = rs1; r_rs2[i] = rs2; r_imm[i] = imm;
    endtask

    task automatic start_burst(input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l);
        @(posedge clk); #1;
        start = 1'b1; start_addr = a; len = l;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Drives n queued requests into a burst and records every drained word.
    task automatic run_stream(input logic [ADDR_W-1:0] a, input int n, input int ready_mode,
                              input bit poke_start);
        int idx;
        logic prev_stall;
        logic [31:0] p_instr;
        logic [ADDR_W-1:0] p_addr;
        logic p_err;
        nout = 0; n_stall_viol = 0; done_cnt = 0; idx = 0; prev_stall = 1'b0;
        p_instr = '0; p_addr = '0; p_err = 1'b0;
        start_burst(a, LEN_W'(n));
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (idx < n) begin
                in_valid = 1'b1;
                in_fmt = r_fmt[idx]; in_opcode = r_op[idx]; in_funct3 = r_f3[idx];
                in_funct7 = r_f7[idx]; in_rd = r_rd[idx]; in_rs1 = r_rs1[idx];
                in_rs2 = r_rs2[idx]; in_imm = r_imm[idx];
            end else begin
                in_valid = 1'b0;
            end
            out_ready  = (ready_mode == 0) ? 1'b1 : ((cyc % 2) == 0);
            start      = poke_start && (cyc == 2);
            start_addr = 10'h005;
            len        = '0;
            @(negedge clk);
            if (out_valid) begin
                if (prev_stall && (out_instr !== p_instr || out_addr !== p_addr || out_err !== p_err))
                    n_stall_viol++;
                if (out_ready) begin
                    if (nout < MAXN) begin
                        got_instr[nout] = out_instr;
                        got_addr[nout]  = out_addr;
                        got_err[nout]   = out_err;
                    end
                    nout++;
                end
            end
            prev_stall = out_valid && !out_ready;
            p_instr = out_instr; p_addr = out_addr; p_err = out_err;
            if (in_valid && in_ready) idx++;
            if (done) begin
                done_cnt++;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        in_valid = 1'b0; start = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({out_valid, out_err, done, busy, in_ready} !== 5'b0) begin
            bad++; $display("FAIL reset_flags got=%b want=00000", {out_valid, out_err, done, busy, in_ready});
        end
        total++;
        if (out_instr !== 32'h0) begin bad++; $display("FAIL reset_instr got=%h want=0", out_instr); end
        total++;
        if (out_addr !== '0) begin bad++; $display("FAIL reset_addr got=%h want=0", out_addr); end
        total++;
        if (err_cnt !== 8'd0) begin bad++; $display("FAIL reset_err_cnt got=%0d want=0", err_cnt); end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_r_type();
        set_req(0, 3'd0, 7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 32'h0);
        run_stream(10'h000, 1, 0, 1'b0);
        total++;
        if (done_cnt !== 1) begin bad++; $display("FAIL r_done got=%0d want=1", done_cnt); end
        total++;
        if (nout !== 1) begin bad++; $display("FAIL r_nout got=%0d want=1", nout); end
        total++;
        if (got_instr[0] !== 32'h002081B3) begin bad++; $display("FAIL r_add got=%h want=002081b3", got_instr[0]); end
        total++;
        if ({got_addr[0], got_err[0]} !== {10'h000, 1'b0}) begin
            bad++; $display("FAIL r_addr_err got=%h/%b want=000/0", got_addr[0], got_err[0]);
        end
        total++;
        if (err_cnt !== 8'd0) begin bad++; $display("FAIL r_err_cnt got=%0d want=0", err_cnt); end
    endtask

    task automatic test_i_type();
        logic [31:0] exp_i [6];
        logic        exp_e [6];
        set_req(0, 3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF);
        set_req(1, 3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd2048);
        set_req(2, 3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'hFFFF_F800);
        set_req(3, 3'd1, 7'h13, 3'd1, 7'h00, 5'd1, 5'd1, 5'd0, 32'd3);
        set_req(4, 3'd1, 7'h13, 3'd5, 7'h20, 5'd2, 5'd2, 5'd0, 32'd4);
        set_req(5, 3'd1, 7'h13, 3'd1, 7'h00, 5'd1, 5'd1, 5'd0, 32'd32);
        exp_i = '{32'hFFF00093, 32'h0, 32'h80000093, 32'h00309093, 32'h40415113, 32'h0};
        exp_e = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        run_stream(10'h020, 6, 0, 1'b0);
        total++;
        if (nout !== 6) begin bad++; $display("FAIL i_nout got=%0d want=6", nout); end
        for (int i = 0; i < 6; i++) begin
            total++;
            if ({got_instr[i], got_err[i], got_addr[i]} !== {exp_i[i], exp_e[i], 10'(10'h020 + i)}) begin
                bad++;
                $display("FAIL i_word%0d got=%h/%b@%h want=%h/%b@%h", i, got_instr[i], got_err[i],
                         got_addr[i], exp_i[i], exp_e[i], 10'(10'h020 + i));
            end
        end
        total++;
        if (err_cnt !== 8'd2) begin bad++; $display("FAIL i_err_cnt got=%0d want=2", err_cnt); end
    endtask

    task automatic test_sbju();
        logic [31:0] exp_i [10];
        logic        exp_e [10];
        set_req(0, 3'd2, 7'h23, 3'd2, 7'h00, 5'd0, 5'd1, 5'd2, 32'd8);
        set_req(1, 3'd3, 7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC);
        set_req(2, 3'd4, 7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd2048);
        set_req(3, 3'd4, 7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd3);
        set_req(4, 3'd3, 7'h63, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'd4096);
        set_req(5, 3'd3, 7'h63, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'hFFFF_F000);
        set_req(6, 3'd4, 7'h6F, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFE);
        set_req(7, 3'd5, 7'h37, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h1234_5000);
        set_req(8, 3'd5, 7'h37, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h0000_0123);
        set_req(9, 3'd6, 7'h33, 3'd0, 7'h00, 5'd1, 5'd1, 5'd1, 32'h0);
        exp_i = '{32'h0020A423, 32'hFE208EE3, 32'h001000EF, 32'h0, 32'h0,
                  32'h80000063, 32'hFFFFF06F, 32'h123452B7, 32'h0, 32'h0};
        exp_e = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        run_stream(10'h100, 10, 0, 1'b0);
        total++;
        if (nout !== 10) begin bad++; $display("FAIL sbju_nout got=%0d want=10", nout); end
        for (int i = 0; i < 10; i++) begin
            total++;
            if ({got_instr[i], got_err[i]} !== {exp_i[i], exp_e[i]}) begin
                bad++;
                $display("FAIL sbju_word%0d got=%h/%b want=%h/%b", i, got_instr[i], got_err[i], exp_i[i], exp_e[i]);
            end
        end
        total++;
        if (err_cnt !== 8'd4) begin bad++; $display("FAIL sbju_err_cnt got=%0d want=4", err_cnt); end
    endtask

    task automatic test_stall();
        logic [31:0] exp_i [4];
        exp_i = '{32'h00100093, 32'h00200113, 32'h00300193, 32'h00400213};
        for (int i = 0; i < 4; i++)
            set_req(i, 3'd1, 7'h13, 3'd0, 7'h00, 5'(i + 1), 5'd0, 5'd0, 32'(i + 1));
        run_stream(10'h010, 4, 1, 1'b0);
        total++;
        if (nout !== 4) begin bad++; $display("FAIL stall_nout got=%0d want=4", nout); end
        total++;
        if (n_stall_viol !== 0) begin bad++; $display("FAIL stall_hold got=%0d want=0", n_stall_viol); end
        total++;
        if (done_cnt !== 1) begin bad++; $display("FAIL stall_done got=%0d want=1", done_cnt); end
        for (int i = 0; i < 4; i++) begin
            total++;
            if ({got_instr[i], got_addr[i]} !== {exp_i[i], 10'(10'h010 + i)}) begin
                bad++;
                $display("FAIL stall_word%0d got=%h@%h want=%h@%h", i, got_instr[i], got_addr[i],
                         exp_i[i], 10'(10'h010 + i));
            end
        end
    endtask

    task automatic test_wrap();
        logic [ADDR_W-1:0] exp_a [3];
        exp_a = '{10'h3FE, 10'h3FF, 10'h000};
        for (int i = 0; i < 3; i++)
            set_req(i, 3'd0, 7'h33, 3'd0, 7'h00, 5'(i), 5'd1, 5'd2, 32'h0);
        run_stream(10'h3FE, 3, 0, 1'b1);
        total++;
        if (nout !== 3) begin bad++; $display("FAIL wrap_nout got=%0d want=3", nout); end
        total++;
        if (done_cnt !== 1) begin bad++; $display("FAIL wrap_done got=%0d want=1", done_cnt); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL wrap_idle got=%b want=0", busy); end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (got_addr[i] !== exp_a[i]) begin
                bad++; $display("FAIL wrap_addr%0d got=%h want=%h", i, got_addr[i], exp_a[i]);
            end
        end
    endtask

    task automatic test_err_sat();
        int n_bad_word;
        for (int i = 0; i < 260; i++)
            set_req(i, 3'd7, 7'h13, 3'd0, 7'h00, 5'd1, 5'd1, 5'd1, 32'h0);
        run_stream(10'h000, 260, 0, 1'b0);
        n_bad_word = 0;
        for (int i = 0; i < 260; i++)
            if (got_instr[i] !== 32'h0 || got_err[i] !== 1'b1) n_bad_word++;
        total++;
        if (nout !== 260) begin bad++; $display("FAIL sat_nout got=%0d want=260", nout); end
        total++;
        if (n_bad_word !== 0) begin bad++; $display("FAIL sat_words got=%0d want=0", n_bad_word); end
        total++;
        if (err_cnt !== 8'd255) begin bad++; $display("FAIL sat_err_cnt got=%0d want=255", err_cnt); end
    endtask

    task automatic test_reset_mid();
        bit seen;
        int n_done;
        set_req(0, 3'd0, 7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 32'h0);
        start_burst(10'h055, 10'd4);
        in_valid = 1'b1; out_ready = 1'b0;
        in_fmt = r_fmt[0]; in_opcode = r_op[0]; in_funct3 = r_f3[0]; in_funct7 = r_f7[0];
        in_rd = r_rd[0]; in_rs1 = r_rs1[0]; in_rs2 = r_rs2[0]; in_imm = r_imm[0];
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b1) begin bad++; $display("FAIL rmid_valid got=%b want=1", seen); end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({out_valid, busy, done, in_ready} !== 4'b0) begin
            bad++; $display("FAIL rmid_flags got=%b want=0000", {out_valid, busy, done, in_ready});
        end
        total++;
        if ({out_instr, out_addr} !== {32'h0, 10'h000}) begin
            bad++; $display("FAIL rmid_data got=%h@%h want=0@0", out_instr, out_addr);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        n_done = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        total++;
        if (n_done !== 0) begin bad++; $display("FAIL rmid_no_done got=%0d want=0", n_done); end
    endtask

    task automatic test_len0();
        start_burst(10'h007, 10'd0);
        @(negedge clk);
        total++;
        if ({done, busy, out_valid} !== 3'b110) begin
            bad++; $display("FAIL len0_done got=%b want=110", {done, busy, out_valid});
        end
        @(negedge clk);
        total++;
        if ({done, busy} !== 2'b00) begin bad++; $display("FAIL len0_idle got=%b want=00", {done, busy}); end
        total++;
        if (out_addr !== 10'h007) begin bad++; $display("FAIL len0_addr got=%h want=007", out_addr); end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; start_addr = '0; len = '0;
        in_valid = 1'b0; in_fmt = '0; in_opcode = '0; in_funct3 = '0; in_funct7 = '0;
        in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0; out_ready = 1'b1;
        test_reset();
        test_r_type();
        test_i_type();
        test_sbju();
        test_stall();
        test_wrap();
        test_err_sat();
        test_reset_mid();
        test_len0();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
